// File: rtl/control_unit.sv
// Hard-wired Moore sequencer for the Mini SRC datapath.
// Runs fetch (T0-T2), then an execute sequence (T3-T7) chosen by the opcode
// captured at the T2->T3 edge. Memory-read steps are held for MEM_LAT cycles.
// After the last step of each instruction the sequencer returns to T0, or
// enters HALT if the instruction was halt or stop was high at that edge.
// HALT is left only through clr.
module control_unit #(
    parameter int          MEM_LAT = 1,        // 1..4 cycles per memory read
    parameter logic [4:0]  ALU_ADD = 5'b00011  // ALU code for address/PC adds
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        stop,
    output logic        Pout,
    output logic        MARen,
    output logic        MDRen,
    output logic        MDROut,
    output logic        IRen,
    output logic        Read,
    output logic        Write,
    output logic        Yen,
    output logic        Pen,
    output logic        IncPC,
    output logic        ZHIen,
    output logic        ZLOen,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        HIen,
    output logic        LOen,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        ConIn,
    output logic [4:0]  alu_control,
    output logic        run,
    output logic [3:0]  step,
    output logic        done
);

    // Step encoding doubles as the debug step output (HALT reads as 15).
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd15
    } state_e;

    // Instruction families that share an execute sequence.
    typedef enum logic [3:0] {
        C_LD,
        C_LDI,
        C_ST,
        C_ALU3,     // add..rol: two register operands
        C_IMM,      // addi/andi/ori: register and constant
        C_UNARY,    // neg/not
        C_MULDIV,
        C_BR,
        C_MFHI,
        C_MFLO,
        C_HALT,
        C_NOP       // nop and every undefined opcode
    } op_class_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Last count value of a stretched memory-read step.
    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    state_e     r_state;
    state_e     w_next;
    logic [4:0] r_op;
    logic [1:0] r_wait;
    op_class_e  w_class;
    logic       w_stretch;
    logic       w_wait_last;
    logic       w_unused_ir;

    // Only the opcode field is consumed here; the rest belongs to the datapath.
    assign w_unused_ir = ^IR[26:0];
    assign w_wait_last = (r_wait == WAIT_LAST);

    // State register, opcode capture at the end of fetch, memory wait counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_T0;
            r_op    <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_op <= IR[31:27];
            end
            // Counter runs only inside a stretched step and is cleared
            // otherwise, so each memory read starts from zero.
            if (w_stretch && !w_wait_last) begin
                r_wait <= r_wait + 2'd1;
            end else begin
                r_wait <= '0;
            end
        end
    end

    // Map the captured opcode onto its execute-sequence family.
    always_comb begin
        w_class = C_NOP;
        case (r_op) inside
            OP_LD:             w_class = C_LD;
            OP_LDI:            w_class = C_LDI;
            OP_ST:             w_class = C_ST;
            [OP_ADD:OP_ROL]:   w_class = C_ALU3;
            [OP_ADDI:OP_ORI]:  w_class = C_IMM;
            OP_MUL, OP_DIV:    w_class = C_MULDIV;
            OP_NEG, OP_NOT:    w_class = C_UNARY;
            OP_BR:             w_class = C_BR;
            OP_MFHI:           w_class = C_MFHI;
            OP_MFLO:           w_class = C_MFLO;
            OP_HALT:           w_class = C_HALT;
            default:           w_class = C_NOP;
        endcase
    end

    // Next-step selection and per-step strobe decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        w_stretch   = 1'b0;
        Pout        = 1'b0;
        MARen       = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        Yen         = 1'b0;
        Pen         = 1'b0;
        IncPC       = 1'b0;
        ZHIen       = 1'b0;
        ZLOen       = 1'b0;
        ZHIout      = 1'b0;
        ZLOout      = 1'b0;
        HIen        = 1'b0;
        LOen        = 1'b0;
        HIout       = 1'b0;
        LOout       = 1'b0;
        Cout        = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        BAout       = 1'b0;
        ConIn       = 1'b0;
        alu_control = 5'd0;
        run         = 1'b1;
        step        = r_state;
        done        = 1'b0;

        case (r_state)
            S_T0: begin
                Pout = 1'b1; MARen = 1'b1; IncPC = 1'b1; ZLOen = 1'b1;
                alu_control = ALU_ADD;
                w_next = S_T1;
            end
            S_T1: begin
                ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1;
                w_stretch = 1'b1;
                if (w_wait_last) w_next = S_T2;
            end
            S_T2: begin
                MDROut = 1'b1; IRen = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                w_next = S_T4;
                case (w_class)
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yen = 1'b1; end
                    C_ALU3, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; end
                    C_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; ZLOen = 1'b1;
                        alu_control = r_op;
                    end
                    C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yen = 1'b1; end
                    C_BR:     begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
                    C_MFHI:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                    C_MFLO:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                    default:  done = 1'b1;
                endcase
            end
            S_T4: begin
                w_next = S_T5;
                case (w_class)
                    C_LD, C_LDI, C_ST: begin
                        Cout = 1'b1; ZLOen = 1'b1; alu_control = ALU_ADD;
                    end
                    C_ALU3: begin
                        Grc = 1'b1; Rout = 1'b1; ZLOen = 1'b1; alu_control = r_op;
                    end
                    C_IMM: begin
                        Cout = 1'b1; ZLOen = 1'b1; alu_control = r_op;
                    end
                    C_UNARY: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                    C_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; ZHIen = 1'b1; ZLOen = 1'b1;
                        alu_control = r_op;
                    end
                    C_BR:    begin Pout = 1'b1; Yen = 1'b1; end
                    default: w_next = S_T0;
                endcase
            end
            S_T5: begin
                w_next = S_T6;
                case (w_class)
                    C_LD, C_ST:            begin ZLOout = 1'b1; MARen = 1'b1; end
                    C_LDI, C_ALU3, C_IMM:  begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                    C_MULDIV:              begin ZLOout = 1'b1; LOen = 1'b1; end
                    C_BR: begin
                        Cout = 1'b1; ZLOen = 1'b1; alu_control = ALU_ADD;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T6: begin
                w_next = S_T7;
                case (w_class)
                    C_LD: begin
                        Read = 1'b1; MDRen = 1'b1;
                        w_stretch = 1'b1;
                        if (!w_wait_last) w_next = S_T6;
                    end
                    C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1; end
                    C_MULDIV: begin ZHIout = 1'b1; HIen = 1'b1; done = 1'b1; end
                    C_BR: begin
                        ZLOout = 1'b1; Pen = CON_FF; done = 1'b1;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T7: begin
                w_next = S_T0;
                case (w_class)
                    C_LD:    begin MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                    C_ST:    begin Write = 1'b1; done = 1'b1; end
                    default: ;
                endcase
            end
            S_HALT: begin
                run = 1'b0;
            end
            default: w_next = S_T0;
        endcase

        // Instruction boundary: stop is only honoured here.
        if (done) begin
            w_next = (stop || w_class == C_HALT) ? S_HALT : S_T0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A table-driven reference model
// expands each opcode into its expected per-cycle strobe pattern, which is
// compared against the DUT on every falling edge.
module tb_control_unit;

    localparam int         MEM_LAT = 3;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    // Strobe bit positions in the packed observation vector.
    localparam logic [25:0] M_POUT   = 26'd1 << 0;
    localparam logic [25:0] M_MAREN  = 26'd1 << 1;
    localparam logic [25:0] M_MDREN  = 26'd1 << 2;
    localparam logic [25:0] M_MDROUT = 26'd1 << 3;
    localparam logic [25:0] M_IREN   = 26'd1 << 4;
    localparam logic [25:0] M_READ   = 26'd1 << 5;
    localparam logic [25:0] M_WRITE  = 26'd1 << 6;
    localparam logic [25:0] M_YEN    = 26'd1 << 7;
    localparam logic [25:0] M_PEN    = 26'd1 << 8;
    localparam logic [25:0] M_INCPC  = 26'd1 << 9;
    localparam logic [25:0] M_ZHIEN  = 26'd1 << 10;
    localparam logic [25:0] M_ZLOEN  = 26'd1 << 11;
    localparam logic [25:0] M_ZHIOUT = 26'd1 << 12;
    localparam logic [25:0] M_ZLOOUT = 26'd1 << 13;
    localparam logic [25:0] M_HIEN   = 26'd1 << 14;
    localparam logic [25:0] M_LOEN   = 26'd1 << 15;
    localparam logic [25:0] M_HIOUT  = 26'd1 << 16;
    localparam logic [25:0] M_LOOUT  = 26'd1 << 17;
    localparam logic [25:0] M_COUT   = 26'd1 << 18;
    localparam logic [25:0] M_GRA    = 26'd1 << 19;
    localparam logic [25:0] M_GRB    = 26'd1 << 20;
    localparam logic [25:0] M_GRC    = 26'd1 << 21;
    localparam logic [25:0] M_RIN    = 26'd1 << 22;
    localparam logic [25:0] M_ROUT   = 26'd1 << 23;
    localparam logic [25:0] M_BAOUT  = 26'd1 << 24;
    localparam logic [25:0] M_CONIN  = 26'd1 << 25;

    typedef struct {
        int          stp;
        logic [25:0] mask;
        logic [4:0]  alu;
        bit          dn;
    } exp_t;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        CON_FF;
    logic        stop;
    logic Pout, MARen, MDRen, MDROut, IRen, Read, Write, Yen, Pen, IncPC;
    logic ZHIen, ZLOen, ZHIout, ZLOout, HIen, LOen, HIout, LOout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, ConIn;
    logic [4:0] alu_control;
    logic       run;
    logic [3:0] step;
    logic       done;

    logic [25:0] obs_mask;
    logic [8:0]  drivers;

    int   checks = 0;
    int   errors = 0;
    bit   halted;
    exp_t exp_q[$];

    control_unit #(.MEM_LAT(MEM_LAT), .ALU_ADD(ALU_ADD)) dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .stop(stop),
        .Pout(Pout), .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut), .IRen(IRen),
        .Read(Read), .Write(Write), .Yen(Yen), .Pen(Pen), .IncPC(IncPC),
        .ZHIen(ZHIen), .ZLOen(ZLOen), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .HIen(HIen), .LOen(LOen), .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .ConIn(ConIn),
        .alu_control(alu_control), .run(run), .step(step), .done(done)
    );

    assign obs_mask = {ConIn, BAout, Rout, Rin, Grc, Grb, Gra, Cout, LOout, HIout,
                       LOen, HIen, ZLOout, ZHIout, ZLOen, ZHIen, IncPC, Pen, Yen,
                       Write, Read, IRen, MDROut, MDRen, MARen, Pout};
    assign drivers  = {Pout, MDROut, ZHIout, ZLOout, HIout, LOout, Cout, Rout, BAout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Append one step of the expected sequence, repeated reps cycles.
    function automatic void add(input int stp, input logic [25:0] mask,
                                input logic [4:0] alu, input bit dn, input int reps);
        exp_t e;
        e.stp = stp; e.mask = mask; e.alu = alu; e.dn = dn;
        for (int r = 0; r < reps; r++) exp_q.push_back(e);
    endfunction

    // Reference model: full expected cycle list for one instruction.
    function automatic void build(input logic [4:0] op, input bit con);
        exp_q.delete();
        add(0, M_POUT | M_MAREN | M_INCPC | M_ZLOEN, ALU_ADD, 0, 1);
        add(1, M_ZLOOUT | M_PEN | M_READ | M_MDREN, 5'd0, 0, MEM_LAT);
        add(2, M_MDROUT | M_IREN, 5'd0, 0, 1);
        case (op) inside
            5'd0, 5'd1, 5'd2: begin
                add(3, M_GRB | M_BAOUT | M_YEN, 5'd0, 0, 1);
                add(4, M_COUT | M_ZLOEN, ALU_ADD, 0, 1);
                if (op == 5'd1) begin
                    add(5, M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1, 1);
                end else begin
                    add(5, M_ZLOOUT | M_MAREN, 5'd0, 0, 1);
                    if (op == 5'd0) begin
                        add(6, M_READ | M_MDREN, 5'd0, 0, MEM_LAT);
                        add(7, M_MDROUT | M_GRA | M_RIN, 5'd0, 1, 1);
                    end else begin
                        add(6, M_GRA | M_ROUT | M_MDREN, 5'd0, 0, 1);
                        add(7, M_WRITE, 5'd0, 1, 1);
                    end
                end
            end
            [5'd3:5'd11]: begin
                add(3, M_GRB | M_ROUT | M_YEN, 5'd0, 0, 1);
                add(4, M_GRC | M_ROUT | M_ZLOEN, op, 0, 1);
                add(5, M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1, 1);
            end
            [5'd12:5'd14]: begin
                add(3, M_GRB | M_ROUT | M_YEN, 5'd0, 0, 1);
                add(4, M_COUT | M_ZLOEN, op, 0, 1);
                add(5, M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1, 1);
            end
            5'd15, 5'd16: begin
                add(3, M_GRA | M_ROUT | M_YEN, 5'd0, 0, 1);
                add(4, M_GRB | M_ROUT | M_ZHIEN | M_ZLOEN, op, 0, 1);
                add(5, M_ZLOOUT | M_LOEN, 5'd0, 0, 1);
                add(6, M_ZHIOUT | M_HIEN, 5'd0, 1, 1);
            end
            5'd17, 5'd18: begin
                add(3, M_GRB | M_ROUT | M_ZLOEN, op, 0, 1);
                add(4, M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1, 1);
            end
            5'd19: begin
                add(3, M_GRA | M_ROUT | M_CONIN, 5'd0, 0, 1);
                add(4, M_POUT | M_YEN, 5'd0, 0, 1);
                add(5, M_COUT | M_ZLOEN, ALU_ADD, 0, 1);
                add(6, M_ZLOOUT | (con ? M_PEN : 26'd0), 5'd0, 1, 1);
            end
            5'd24:   add(3, M_HIOUT | M_GRA | M_RIN, 5'd0, 1, 1);
            5'd25:   add(3, M_LOOUT | M_GRA | M_RIN, 5'd0, 1, 1);
            default: add(3, 26'd0, 5'd0, 1, 1);
        endcase
    endfunction

    task automatic check_cycle(input string tag, input exp_t e);
        check($sformatf("%s T%0d step", tag, e.stp), 32'(step), 32'(e.stp));
        check($sformatf("%s T%0d strobes", tag, e.stp), 32'(obs_mask), 32'(e.mask));
        check($sformatf("%s T%0d alu", tag, e.stp), 32'(alu_control), 32'(e.alu));
        check($sformatf("%s T%0d done", tag, e.stp), 32'(done), 32'(e.dn));
        check($sformatf("%s T%0d run", tag, e.stp), 32'(run), 32'd1);
        check($sformatf("%s T%0d rw_excl", tag, e.stp), 32'(Read & Write), 32'd0);
        check($sformatf("%s T%0d one_driver", tag, e.stp),
              32'($countones(drivers) > 1), 32'd0);
    endtask

    // Runs one instruction from T0. stop is randomised except on the done
    // cycle, where it takes stop_done. abort_step >= 0 pulses clr in the
    // first cycle of that step.
    task automatic exec(input string tag, input logic [4:0] op, input bit con,
                        input bit stop_done, input int abort_step);
        build(op, con);
        IR     = {op, 27'($urandom)};
        CON_FF = con;
        halted = 1'b0;
        foreach (exp_q[i]) begin
            check_cycle(tag, exp_q[i]);
            if (exp_q[i].stp == abort_step) begin
                clr = 1'b1;
                @(negedge clk);
                clr  = 1'b0;
                stop = 1'b0;
                return;
            end
            if (exp_q[i].stp >= 3) IR = $urandom;
            stop = exp_q[i].dn ? stop_done : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        halted = stop_done || (op == 5'b11011);
        stop   = 1'b0;
    endtask

    task automatic check_halt(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, " halt step"}, 32'(step), 32'd15);
            check({tag, " halt run"}, 32'(run), 32'd0);
            check({tag, " halt strobes"}, 32'(obs_mask), 32'd0);
            check({tag, " halt alu"}, 32'(alu_control), 32'd0);
            check({tag, " halt done"}, 32'(done), 32'd0);
            stop = 1'($urandom_range(0, 1));
            IR   = $urandom;
            @(negedge clk);
        end
        clr = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input bit con,
                          input bit stop_done);
        exec(tag, op, con, stop_done, -1);
        if (halted) check_halt(tag);
    endtask

    initial begin
        clr    = 1'b1;
        stop   = 1'b0;
        IR     = '0;
        CON_FF = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;

        run_op("add",   5'b00011, 1'b0, 1'b0);
        run_op("ld",    5'b00000, 1'b0, 1'b0);
        run_op("br_t",  5'b10011, 1'b1, 1'b0);
        run_op("br_f",  5'b10011, 1'b0, 1'b0);
        run_op("mul",   5'b01111, 1'b0, 1'b0);
        run_op("div",   5'b10000, 1'b1, 1'b0);
        run_op("neg",   5'b10001, 1'b0, 1'b0);
        run_op("not",   5'b10010, 1'b0, 1'b0);
        run_op("andi",  5'b01101, 1'b0, 1'b0);
        run_op("st",    5'b00010, 1'b0, 1'b0);
        run_op("ldi",   5'b00001, 1'b0, 1'b0);
        run_op("mfhi",  5'b11000, 1'b0, 1'b0);
        run_op("mflo",  5'b11001, 1'b0, 1'b0);
        run_op("nop",   5'b11010, 1'b0, 1'b0);
        run_op("undef", 5'b11101, 1'b0, 1'b0);
        run_op("add_stop", 5'b00011, 1'b0, 1'b1);
        run_op("halt",  5'b11011, 1'b0, 1'b0);

        exec("ld_clr", 5'b00000, 1'b0, 1'b0, 6);
        run_op("ld_after_clr", 5'b00000, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rnd%0d", n), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
